// File: rtl/dmux4way16_buf_pkg.sv
// Shared constants and types for the buffered 1-to-4 word demultiplexer.
// Channel count, select width and per-channel FIFO sizing live here.
package dmux4way16_buf_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int NUM_CH        = 4;
  localparam int CH_SEL_W      = 2;
  localparam int DEPTH         = 2;
  localparam int CNT_W         = $clog2(DEPTH + 1);

  typedef logic [CH_SEL_W-1:0] ch_sel_t;

  localparam ch_sel_t CH0 = 2'd0;
  localparam ch_sel_t CH1 = 2'd1;
  localparam ch_sel_t CH2 = 2'd2;
  localparam ch_sel_t CH3 = 2'd3;

  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_sel_t sel);
    logic [NUM_CH-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dmux4way16_buf_chan_fifo.sv
// Two-entry per-channel FIFO: head register plus one tail slot.
// The head holds its last value when the channel drains to empty.
module dmux_chan_fifo
  import dmux4way16_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             valid
);

  logic [WIDTH-1:0] tail;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (count < CNT_W'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign valid   = (count != '0);

  // NOTE: the data slots are reset too, because the head word is a visible output that must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == '0) head <= din;
          else             tail <= din;
          count <= count + 1'b1;
        end
        2'b01: begin
          if (count == CNT_W'(2)) head <= tail;
          count <= count - 1'b1;
        end
        2'b11: begin
          // Push and pop together: depth unchanged, order preserved.
          if (count == CNT_W'(1)) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmux4way16_buf.sv
// Buffered 1-to-4 demultiplexer: routes one valid/ready word stream to four
// buffered channels by explicit select or by round-robin.
module dmux4way16_buf
  import dmux4way16_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              auto_mode,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [1:0]        rr_ptr
);

  ch_sel_t           dest;
  logic              accept;
  logic [CNT_W-1:0]  count [NUM_CH];
  logic [WIDTH-1:0]  head  [NUM_CH];
  logic [NUM_CH-1:0] push_vec;
  logic [NUM_CH-1:0] pop_vec;

  assign dest = auto_mode ? rr_ptr : in_sel;

  // Readiness looks only at registered depth, never at out_ready.
  assign in_ready = !rst && (count[dest] < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push_vec = accept ? ch_onehot(dest) : '0;
  assign pop_vec  = out_valid & out_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    dmux_chan_fifo #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_vec[k]),
      .pop   (pop_vec[k]),
      .din   (in_data),
      .head  (head[k]),
      .count (count[k]),
      .valid (out_valid[k])
    );
  end

  assign out0 = head[CH0];
  assign out1 = head[CH1];
  assign out2 = head[CH2];
  assign out3 = head[CH3];

  // Advances only on an accepted auto-mode word, so a full target stalls it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       rr_ptr <= '0;
    else if (accept && auto_mode)  rr_ptr <= rr_ptr + 1'b1;
  end

endmodule

// File: tb/tb_dmux4way16_buf.sv
// Self-checking bench for dmux4way16_buf: queue-based reference model,
// per-cycle comparison, directed scenarios and a randomized phase.
module tb_dmux4way16_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        auto_mode;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0, out1, out2, out3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q [4][$];
  int          m_rr;
  logic [15:0] outs [4];

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;

  dmux4way16_buf dut (
    .clk       (clk),
    .rst       (rst),
    .auto_mode (auto_mode),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one FIFO queue per channel, pops before the push.
  always @(posedge clk or posedge rst) begin
    int  d;
    bit  acc;
    if (rst) begin
      for (int k = 0; k < 4; k++) q[k].delete();
      m_rr <= 0;
    end else begin
      d   = auto_mode ? m_rr : int'(in_sel);
      acc = in_valid && (q[d].size() < 2);
      for (int k = 0; k < 4; k++)
        if (out_ready[k] && q[k].size() > 0) void'(q[k].pop_front());
      if (acc) begin
        q[d].push_back(in_data);
        if (auto_mode) m_rr <= (m_rr + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    int         d;
    logic [3:0] ev;
    if (rst) begin
      check("in_ready_in_reset", in_ready, 0);
    end else begin
      d = auto_mode ? m_rr : int'(in_sel);
      check("in_ready", in_ready, q[d].size() < 2);
      for (int k = 0; k < 4; k++) ev[k] = q[k].size() > 0;
      check("out_valid", out_valid, ev);
      check("rr_ptr", rr_ptr, m_rr);
      for (int k = 0; k < 4; k++)
        if (q[k].size() > 0) check($sformatf("head%0d", k), outs[k], q[k][0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] s);
    bit r;
    bit ok;
    ok       = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #2;
      if (r) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  initial begin
    rst       = 1'b1;
    auto_mode = 1'b0;
    in_data   = 16'hDEAD;
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    out_ready = 4'h0;
    #1;
    check("rst_out_valid", out_valid, 4'h0);
    check("rst_rr_ptr", rr_ptr, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    check("rst_out2", out2, 0);
    check("rst_out3", out3, 0);
    cyc(2);
    rst      = 1'b0;
    in_valid = 1'b0;
    cyc(1);

    // Directed select, consumers always ready.
    out_ready = 4'hF;
    send(16'h1111, 2'd0);
    check("sel0_valid", out_valid, 4'b0001);
    check("sel0_data", out0, 16'h1111);
    send(16'h2222, 2'd1);
    check("sel1_valid", out_valid, 4'b0010);
    check("sel1_data", out1, 16'h2222);
    send(16'h3333, 2'd2);
    check("sel2_valid", out_valid, 4'b0100);
    check("sel2_data", out2, 16'h3333);
    send(16'h4444, 2'd3);
    check("sel3_valid", out_valid, 4'b1000);
    check("sel3_data", out3, 16'h4444);
    cyc(1);

    // Back-pressure on channel 2.
    out_ready = 4'h0;
    send(16'hA001, 2'd2);
    send(16'hA002, 2'd2);
    in_valid = 1'b1;
    in_data  = 16'hA003;
    in_sel   = 2'd2;
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
    end
    cyc(1);
    send(16'hB000, 2'd1);
    check("bp_valid", out_valid, 4'b0110);
    check("bp_head_a001", out2, 16'hA001);
    out_ready = 4'b0100;
    cyc(1);
    check("bp_head_a002", out2, 16'hA002);
    send(16'hA003, 2'd2);
    check("bp_head_a003", out2, 16'hA003);
    out_ready = 4'hF;
    cyc(3);

    // Round-robin wrap; in_sel is ignored.
    out_ready = 4'h0;
    auto_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("rr_seq", rr_ptr, i % 4);
      send(16'(i), 2'd3);
    end
    check("rr_wrap", rr_ptr, 0);
    check("rr_all_valid", out_valid, 4'hF);
    check("rr_ch1_first", out1, 16'h0001);
    out_ready = 4'b0010;
    cyc(1);
    check("rr_ch1_second", out1, 16'h0005);
    out_ready = 4'hF;
    cyc(3);

    // Round-robin stall on a full channel 1.
    out_ready = 4'h0;
    auto_mode = 1'b0;
    send(16'hC001, 2'd1);
    send(16'hC002, 2'd1);
    auto_mode = 1'b1;
    send(16'hC000, 2'd3);
    check("stall_rr_start", rr_ptr, 1);
    in_valid = 1'b1;
    in_data  = 16'h7777;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_rr", rr_ptr, 1);
    end
    @(posedge clk);
    #2;
    out_ready = 4'b0010;
    cyc(1);
    out_ready = 4'b0000;
    send(16'h7777, 2'd3);
    check("stall_rr_after", rr_ptr, 2);
    out_ready = 4'hF;
    cyc(3);

    // Simultaneous push and pop on channel 0 with one word held.
    out_ready = 4'h0;
    auto_mode = 1'b0;
    send(16'h5555, 2'd0);
    out_ready = 4'b0001;
    send(16'h6666, 2'd0);
    check("pp_head", out0, 16'h6666);
    check("pp_valid", out_valid[0], 1);
    out_ready = 4'b0000;
    cyc(1);
    check("pp_still_valid", out_valid[0], 1);
    out_ready = 4'b0001;
    cyc(1);
    check("pp_count_one", out_valid, 4'h0);

    // Asynchronous reset mid-operation.
    out_ready = 4'h0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 2; j++)
        send(16'hD000 | 16'(k << 4) | 16'(j), 2'(k));
    check("mid_full", out_valid, 4'hF);
    check("mid_rr", rr_ptr, 2);
    in_valid = 1'b1;
    in_data  = 16'hEEEE;
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", out_valid, 4'h0);
    check("async_rr", rr_ptr, 0);
    check("async_in_ready", in_ready, 0);
    #8;
    check("held_in_ready", in_ready, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    cyc(1);
    auto_mode = 1'b1;
    send(16'h9999, 2'd2);
    check("post_rst_valid", out_valid, 4'b0001);
    check("post_rst_data", out0, 16'h9999);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = 16'($urandom);
      in_sel    = 2'($urandom_range(0, 3));
      auto_mode = ($urandom_range(0, 7) == 0) ? ~auto_mode : auto_mode;
      out_ready = 4'($urandom);
      cyc(1);
    end
    in_valid  = 1'b0;
    out_ready = 4'hF;
    cyc(4);
    check("drained", out_valid, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
